// File: rtl/hazard_unit.sv
// Pipeline hazard control: stall/flush, EX forwarding selects,
// data-memory wait FSM with sticky timeout, saturating perf counters.
//
// Ports:
//   clk, rst_n                   clock, async active-low reset
//   rs1_D, rs2_D                 decode-stage source registers
//   rs1_E, rs2_E, Rd_E           execute-stage sources / destination
//   result_src_E                 2'b01 marks a load in EX
//   pcsrc_E                      taken branch or jump resolved in EX
//   Rd_M, Rd_W                   MEM / WB destinations
//   regwrite_M, regwrite_W       MEM / WB register-write enables
//   mem_req_M, mem_ready_M       data-memory request / completion
//   stall_F/D/E/M                hold stage register
//   flush_D/E/W                  clear stage register
//   forward_AE, forward_BE       00 regfile, 01 WB, 10 MEM
//   mem_timeout                  sticky wait timeout
//   stall_cnt, flush_cnt         saturating perf counters
module hazard_unit #(
  parameter int unsigned MAX_WAIT = 16,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       rs1_D,
  input  logic [4:0]       rs2_D,
  input  logic [4:0]       rs1_E,
  input  logic [4:0]       rs2_E,
  input  logic [4:0]       Rd_E,
  input  logic [1:0]       result_src_E,
  input  logic             pcsrc_E,
  input  logic [4:0]       Rd_M,
  input  logic [4:0]       Rd_W,
  input  logic             regwrite_M,
  input  logic             regwrite_W,
  input  logic             mem_req_M,
  input  logic             mem_ready_M,
  output logic             stall_F,
  output logic             stall_D,
  output logic             stall_E,
  output logic             stall_M,
  output logic             flush_D,
  output logic             flush_E,
  output logic             flush_W,
  output logic [1:0]       forward_AE,
  output logic [1:0]       forward_BE,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int unsigned WC_W = $clog2(MAX_WAIT);
  localparam logic [WC_W-1:0] WC_MAX = WC_W'(MAX_WAIT - 1);
  localparam logic [WC_W-1:0] WC_ONE = WC_W'(1);

  typedef enum logic [1:0] {
    S_RUN  = 2'd0,
    S_WAIT = 2'd1,
    S_TOUT = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WC_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic             tout_q, tout_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic lwstall;
  logic mstall;

  function automatic logic [1:0] fwd_sel(
    input logic [4:0] rs
  );
    logic [1:0] sel;
    sel = 2'b00;
    if (regwrite_M && Rd_M != 5'd0 && Rd_M == rs)
      sel = 2'b10;
    else if (regwrite_W && Rd_W != 5'd0 && Rd_W == rs)
      sel = 2'b01;
    return sel;
  endfunction

  assign lwstall = (result_src_E == 2'b01)
                && (Rd_E != 5'd0)
                && (Rd_E == rs1_D || Rd_E == rs2_D);
  assign mstall  = mem_req_M && !mem_ready_M;

  // Reset overrides outputs immediately so the pipeline
  // registers are flushed while rst_n is low.
  always_comb begin
    stall_F    = 1'b0;
    stall_D    = 1'b0;
    stall_E    = 1'b0;
    stall_M    = 1'b0;
    flush_D    = 1'b1;
    flush_E    = 1'b1;
    flush_W    = 1'b1;
    forward_AE = 2'b00;
    forward_BE = 2'b00;
    if (rst_n) begin
      forward_AE = fwd_sel(rs1_E);
      forward_BE = fwd_sel(rs2_E);
      if (mstall) begin
        // Whole pipe frozen; branch/load hazards wait
        stall_F = 1'b1;
        stall_D = 1'b1;
        stall_E = 1'b1;
        stall_M = 1'b1;
        flush_D = 1'b0;
        flush_E = 1'b0;
        flush_W = 1'b1;
      end else begin
        stall_F = lwstall;
        stall_D = lwstall;
        flush_D = pcsrc_E;
        flush_E = lwstall | pcsrc_E;
        flush_W = 1'b0;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    tout_d     = tout_q;
    unique case (state_q)
      S_RUN: begin
        if (mstall) begin
          wait_cnt_d = WC_ONE;
          state_d    = S_WAIT;
          if (WC_ONE == WC_MAX) begin
            state_d = S_TOUT;
            tout_d  = 1'b1;
          end
        end
      end
      S_WAIT: begin
        if (mstall) begin
          wait_cnt_d = wait_cnt_q + WC_ONE;
          if (wait_cnt_d == WC_MAX) begin
            state_d = S_TOUT;
            tout_d  = 1'b1;
          end
        end else begin
          state_d    = S_RUN;
          wait_cnt_d = '0;
        end
      end
      S_TOUT: begin
        // wait_cnt parks at WC_MAX here
        if (!mstall) begin
          state_d    = S_RUN;
          wait_cnt_d = '0;
        end
      end
      default: begin
        state_d    = S_RUN;
        wait_cnt_d = '0;
      end
    endcase
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_F && stall_cnt_q != '1)
      stall_cnt_d = stall_cnt_q + 1'b1;
    if (pcsrc_E && !mstall && flush_cnt_q != '1)
      flush_cnt_d = flush_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_RUN;
      wait_cnt_q  <= '0;
      tout_q      <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      tout_q      <= tout_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign mem_timeout = tout_q;
  assign stall_cnt   = stall_cnt_q;
  assign flush_cnt   = flush_cnt_q;

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit (MAX_WAIT=4, CNT_W=4).
// Hand-set vectors, small saturating counter model.
module tb_hazard_unit;

  localparam int MW = 4;
  localparam int CW = 4;
  localparam int CMAX = 15;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [4:0]    rs1_D, rs2_D, rs1_E, rs2_E, Rd_E;
  logic [1:0]    result_src_E;
  logic          pcsrc_E;
  logic [4:0]    Rd_M, Rd_W;
  logic          regwrite_M, regwrite_W;
  logic          mem_req_M, mem_ready_M;
  logic          stall_F, stall_D, stall_E, stall_M;
  logic          flush_D, flush_E, flush_W;
  logic [1:0]    forward_AE, forward_BE;
  logic          mem_timeout;
  logic [CW-1:0] stall_cnt, flush_cnt;

  int n_chk = 0;
  int n_err = 0;
  int exp_st = 0;
  int exp_fl = 0;

  hazard_unit #(.MAX_WAIT(MW), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .rs1_D(rs1_D), .rs2_D(rs2_D),
    .rs1_E(rs1_E), .rs2_E(rs2_E),
    .Rd_E(Rd_E), .result_src_E(result_src_E),
    .pcsrc_E(pcsrc_E),
    .Rd_M(Rd_M), .Rd_W(Rd_W),
    .regwrite_M(regwrite_M), .regwrite_W(regwrite_W),
    .mem_req_M(mem_req_M), .mem_ready_M(mem_ready_M),
    .stall_F(stall_F), .stall_D(stall_D),
    .stall_E(stall_E), .stall_M(stall_M),
    .flush_D(flush_D), .flush_E(flush_E),
    .flush_W(flush_W),
    .forward_AE(forward_AE), .forward_BE(forward_BE),
    .mem_timeout(mem_timeout),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(
    input string tag,
    input int    got,
    input int    exp
  );
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d", tag, got, exp);
    end
  endtask

  task automatic idle();
    rs1_D = 0; rs2_D = 0; rs1_E = 0; rs2_E = 0;
    Rd_E = 0; result_src_E = 2'b00; pcsrc_E = 0;
    Rd_M = 0; Rd_W = 0;
    regwrite_M = 0; regwrite_W = 0;
    mem_req_M = 0; mem_ready_M = 0;
  endtask

  // Advance one clock, updating the counter model
  // with the stall/flush expected in the cycle just ended.
  task automatic tick(input bit st, input bit fl);
    @(posedge clk);
    if (st && exp_st < CMAX) exp_st++;
    if (fl && exp_fl < CMAX) exp_fl++;
    #1;
  endtask

  task automatic chk_stall(
    input string tag, input int f, input int e
  );
    chk({tag, ".stF"}, stall_F, f);
    chk({tag, ".stD"}, stall_D, f);
    chk({tag, ".stE"}, stall_E, e);
    chk({tag, ".stM"}, stall_M, e);
  endtask

  task automatic chk_flush(
    input string tag,
    input int d, input int e, input int w
  );
    chk({tag, ".flD"}, flush_D, d);
    chk({tag, ".flE"}, flush_E, e);
    chk({tag, ".flW"}, flush_W, w);
  endtask

  task automatic chk_cnt(input string tag);
    chk({tag, ".scnt"}, stall_cnt, exp_st);
    chk({tag, ".fcnt"}, flush_cnt, exp_fl);
  endtask

  initial begin
    // Reset with hazards present: reset values must win
    rst_n = 0;
    idle();
    mem_req_M = 1; result_src_E = 2'b01;
    Rd_E = 5; rs1_D = 5; pcsrc_E = 1;
    regwrite_M = 1; Rd_M = 3; rs1_E = 3;
    #1;
    chk_stall("rst", 0, 0);
    chk_flush("rst", 1, 1, 1);
    chk("rst.fA", forward_AE, 0);
    @(posedge clk); @(posedge clk); #1;
    chk_cnt("rst");
    chk("rst.tout", mem_timeout, 0);

    idle();
    rst_n = 1;
    #1;
    chk_stall("idle", 0, 0);
    chk_flush("idle", 0, 0, 0);

    // 1. load-use stall
    result_src_E = 2'b01; Rd_E = 5; rs1_D = 5;
    #1;
    chk_stall("lw", 1, 0);
    chk_flush("lw", 0, 1, 0);
    tick(1, 0);
    idle();
    #1;
    chk("lw.cnt1", stall_cnt, 1);
    chk("lw.off", stall_F, 0);
    result_src_E = 2'b01; Rd_E = 7; rs2_D = 7;
    #1;
    chk("lw.rs2", stall_D, 1);
    Rd_E = 0; rs1_D = 0; rs2_D = 0;
    #1;
    chk("lw.x0", stall_F, 0);
    result_src_E = 2'b00; Rd_E = 5; rs1_D = 5;
    #1;
    chk("lw.nold", stall_F, 0);
    tick(0, 0);
    idle();

    // 2. forwarding
    regwrite_M = 1; Rd_M = 3;
    regwrite_W = 1; Rd_W = 3;
    rs1_E = 3;
    #1;
    chk("fwd.AM", forward_AE, 2);
    chk("fwd.B0", forward_BE, 0);
    Rd_M = 0;
    #1;
    chk("fwd.AW", forward_AE, 1);
    rs2_E = 3; Rd_M = 3;
    #1;
    chk("fwd.BM", forward_BE, 2);
    regwrite_M = 0;
    #1;
    chk("fwd.BW", forward_BE, 1);
    regwrite_W = 0;
    #1;
    chk("fwd.B00", forward_BE, 0);
    chk("fwd.A00", forward_AE, 0);
    tick(0, 0);
    idle();

    // 3. branch flush, then branch during mem stall
    pcsrc_E = 1;
    #1;
    chk_stall("br", 0, 0);
    chk_flush("br", 1, 1, 0);
    tick(0, 1);
    chk_cnt("br");
    mem_req_M = 1;
    #1;
    chk_stall("brm", 1, 1);
    chk_flush("brm", 0, 0, 1);
    tick(1, 0);
    chk_cnt("brm");
    mem_ready_M = 1;
    #1;
    chk_flush("brr", 1, 1, 0);
    tick(0, 1);
    chk_cnt("brr");
    idle();

    // 4. two wait cycles, no timeout
    mem_req_M = 1;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk_stall($sformatf("mw%0d", i), 1, 1);
      chk(
        $sformatf("mw%0d.flW", i),
        flush_W, 1
      );
      tick(1, 0);
    end
    mem_ready_M = 1;
    #1;
    chk_stall("mwr", 0, 0);
    chk("mwr.flW", flush_W, 0);
    tick(0, 0);
    idle();
    #1;
    chk("mw.tout", mem_timeout, 0);
    chk_cnt("mw");

    // 5. timeout after the 3rd wait cycle
    mem_req_M = 1;
    for (int k = 1; k <= 6; k++) begin
      #1;
      chk($sformatf("to%0d.st", k), stall_F, 1);
      tick(1, 0);
      chk(
        $sformatf("to%0d.tout", k),
        mem_timeout, (k >= 3) ? 1 : 0
      );
    end
    mem_ready_M = 1;
    #1;
    chk("to.rdy", stall_F, 0);
    tick(0, 0);
    chk("to.hold", mem_timeout, 1);
    mem_ready_M = 0;
    #1;
    chk("to.again", stall_M, 1);
    tick(1, 0);
    idle();
    #1;
    chk("to.stick", mem_timeout, 1);
    chk_cnt("to");

    // Counter saturation
    result_src_E = 2'b01; Rd_E = 9; rs1_D = 9;
    pcsrc_E = 1;
    for (int i = 0; i < 20; i++)
      tick(1, 1);
    idle();
    #1;
    chk_cnt("sat");
    chk("sat.s15", stall_cnt, CMAX);
    chk("sat.f15", flush_cnt, CMAX);

    // 6. reset while waiting
    mem_req_M = 1;
    tick(1, 0);
    tick(1, 0);
    rst_n = 0;
    exp_st = 0;
    exp_fl = 0;
    #1;
    chk_stall("rw", 0, 0);
    chk_flush("rw", 1, 1, 1);
    chk_cnt("rw");
    chk("rw.tout", mem_timeout, 0);
    tick(0, 0);
    rst_n = 1;
    // Starts from RUN with wait_cnt cleared
    for (int k = 1; k <= 3; k++) begin
      #1;
      chk($sformatf("rr%0d.st", k), stall_E, 1);
      tick(1, 0);
      chk(
        $sformatf("rr%0d.tout", k),
        mem_timeout, (k >= 3) ? 1 : 0
      );
    end
    idle();
    #1;
    chk_cnt("rr");

    $display(
      "Result: errors=%0d of %0d checks",
      n_err, n_chk
    );
    $finish;
  end

endmodule
